uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter P_NUM_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter P_TIMEOUT, default 2048, giving the maximum cycles to wait for transmitter completion (>=2).
REQ-003 The block SHALL have port i_CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_RESET_N  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port i_REQ  input  P_NUM_REQ  per-requester transmit request, level.
REQ-006 The block SHALL have port i_REQ_DATA  input  8*P_NUM_REQ  per-requester byte; requester n on bits [8n+7:8n].
REQ-007 The block SHALL have port o_GNT  output  P_NUM_REQ  one-hot grant, held for the whole transfer.
REQ-008 The block SHALL have port o_ACK  output  P_NUM_REQ  one-cycle pulse: granted byte fully transmitted.
REQ-009 The block SHALL have port o_TIMEOUT  output  1  one-cycle pulse: transfer abandoned on watchdog expiry.
REQ-010 The block SHALL have port o_BUSY  output  1  high whenever state is not IDLE.
REQ-011 The block SHALL have port o_TX_ENABLE  output  1  load strobe to the UART transmitter.
REQ-012 The block SHALL have port o_TX_DATA  output  8  byte presented to the UART transmitter.
REQ-013 The block SHALL have port i_TX_DONE  input  1  one-cycle pulse from the transmitter after the stop bit.

Function
REQ-014 The block SHALL implement the states IDLE, START, WAIT, DONE and ABORT.
REQ-015 In IDLE with i_REQ non-zero, the block SHALL grant the first requesting index at or above the round-robin pointer, wrapping modulo P_NUM_REQ.
REQ-016 On that edge the block SHALL register o_GNT, latch the granted byte into o_TX_DATA and enter START.
REQ-017 o_TX_ENABLE SHALL be high for exactly the one cycle spent in START; START SHALL always go to WAIT.
REQ-018 Latency from i_REQ sampled high in IDLE to o_TX_ENABLE high SHALL be one cycle.
REQ-019 o_TX_DATA SHALL remain stable from START until the block returns to IDLE, regardless of i_REQ_DATA changes.
REQ-020 In WAIT, a 12-bit watchdog counter SHALL start at 0 and increment each cycle.
REQ-021 In WAIT, i_TX_DONE high SHALL move the block to DONE.
REQ-022 In WAIT, if the counter reaches P_TIMEOUT-1 without i_TX_DONE, the block SHALL move to ABORT.
REQ-023 If i_TX_DONE and watchdog expiry coincide, DONE SHALL win.
REQ-024 DONE SHALL last one cycle, pulse o_ACK at the granted index and go to IDLE.
REQ-025 ABORT SHALL last one cycle, pulse o_TIMEOUT, leave o_ACK low and go to IDLE.
REQ-026 On leaving DONE or ABORT, o_GNT SHALL clear and the pointer SHALL become (granted index + 1) mod P_NUM_REQ.
REQ-027 Deasserting i_REQ after a grant SHALL NOT cancel the transfer; the ACK SHALL still be issued.
REQ-028 i_TX_DONE outside WAIT SHALL be ignored.
REQ-029 Requests arriving outside IDLE SHALL be held off without loss while the level remains asserted.
REQ-030 Minimum back-to-back spacing SHALL be: i_TX_DONE at cycle k, o_ACK at k+1, IDLE at k+2, next o_TX_ENABLE at k+3.

Reset
REQ-031 While i_RESET_N is low, the block SHALL immediately force state IDLE and pointer 0.
REQ-032 While i_RESET_N is low, o_GNT, o_ACK, o_TIMEOUT, o_BUSY, o_TX_ENABLE and o_TX_DATA SHALL be 0, and the watchdog SHALL be 0.
REQ-033 Reset asserted mid-transfer SHALL discard the transfer with no ACK and no TIMEOUT pulse.
REQ-034 After reset release, the first arbitration SHALL occur on the first rising edge with i_RESET_N high.

Verification
REQ-035 Single request: i_REQ=4'b0001, data0=8'h80, i_TX_DONE 10 cycles after START -> o_TX_ENABLE one cycle with o_TX_DATA=8'h80, o_ACK=4'b0001 one cycle later, o_GNT cleared.
REQ-036 Round-robin: i_REQ=4'b1111 held, immediate DONE each time -> grant order 0,1,2,3,0, each transfer acknowledged once.
REQ-037 Timeout: P_TIMEOUT=16, grant requester 2, no i_TX_DONE -> o_TIMEOUT pulse exactly 16 cycles after entering WAIT, no o_ACK, pointer=3.
REQ-038 Request drop and data change: grant requester 1, then deassert i_REQ[1] and change data1 in WAIT -> o_TX_DATA unchanged, o_ACK[1] still pulses on DONE.
REQ-039 Reset mid-WAIT: assert i_RESET_N low -> all outputs 0 in the same cycle; after release with i_REQ=4'b1000, grant goes to requester 3 with pointer starting at 0.
REQ-040 Spurious done and coincidence: i_TX_DONE in IDLE -> no effect; i_TX_DONE on the watchdog-expiry cycle -> o_ACK pulses and o_TIMEOUT stays low.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that lets several requesters share one
// UART transmitter. A granted byte is loaded into the transmitter with a
// one-cycle strobe, then the block waits for the transmitter's done pulse
// (bounded by a watchdog) before acknowledging and moving the pointer on.
module uart_tx_arbiter #(
    parameter int P_NUM_REQ = 4,
    parameter int P_TIMEOUT = 2048
) (
    input  logic                   i_CLK,
    input  logic                   i_RESET_N,
    input  logic [P_NUM_REQ-1:0]   i_REQ,
    input  logic [8*P_NUM_REQ-1:0] i_REQ_DATA,
    output logic [P_NUM_REQ-1:0]   o_GNT,
    output logic [P_NUM_REQ-1:0]   o_ACK,
    output logic                   o_TIMEOUT,
    output logic                   o_BUSY,
    output logic                   o_TX_ENABLE,
    output logic [7:0]             o_TX_DATA,
    input  logic                   i_TX_DONE
);

    localparam int PTR_W = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] ABORT = 3'd4;

    // Last watchdog value tolerated before the transfer is abandoned.
    localparam logic [11:0] WDOG_LAST = 12'(P_TIMEOUT - 1);
    localparam logic [P_NUM_REQ-1:0] GNT_ONE = {{(P_NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(P_NUM_REQ - 1);

    logic [2:0]           state_reg;
    logic [PTR_W-1:0]     ptr_reg;
    logic [PTR_W-1:0]     gnt_idx_reg;
    logic [P_NUM_REQ-1:0] gnt_reg;
    logic [7:0]           tx_data_reg;
    logic [11:0]          wdog_reg;

    logic [PTR_W-1:0]     ptr_next;
    logic                 arb_found;
    logic [PTR_W-1:0]     arb_idx;
    int                   arb_cand;
    logic [PTR_W-1:0]     arb_cand_idx;

    logic [7:0] req_byte [P_NUM_REQ];

    // Split the flat data bus into one byte per requester.
    generate
        for (genvar gi = 0; gi < P_NUM_REQ; gi++) begin : g_req_byte
            assign req_byte[gi] = i_REQ_DATA[8*gi +: 8];
        end
    endgenerate

    // Scan upward from the pointer (wrapping) and pick the first active request.
    always_comb begin
        arb_found    = 1'b0;
        arb_idx      = '0;
        arb_cand     = 0;
        arb_cand_idx = '0;
        for (int off = 0; off < P_NUM_REQ; off++) begin
            arb_cand = int'(ptr_reg) + off;
            if (arb_cand >= P_NUM_REQ) begin
                arb_cand = arb_cand - P_NUM_REQ;
            end
            arb_cand_idx = PTR_W'(arb_cand);
            if (!arb_found && i_REQ[arb_cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand_idx;
            end
        end
    end

    // Pointer moves to the requester just after the one that was served.
    assign ptr_next = (gnt_idx_reg == LAST_IDX) ? '0 : gnt_idx_reg + 1'b1;

    // Transfer sequencer: grant, strobe, wait for done or watchdog, release.
    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            gnt_idx_reg <= '0;
            gnt_reg     <= '0;
            tx_data_reg <= '0;
            wdog_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (arb_found) begin
                        gnt_idx_reg <= arb_idx;
                        gnt_reg     <= GNT_ONE << arb_idx;
                        tx_data_reg <= req_byte[arb_idx];
                        state_reg   <= START;
                    end
                end
                START: begin
                    wdog_reg  <= '0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    // Done is checked first so it wins on the expiry cycle.
                    if (i_TX_DONE) begin
                        state_reg <= DONE;
                    end else if (wdog_reg == WDOG_LAST) begin
                        state_reg <= ABORT;
                    end else begin
                        wdog_reg <= wdog_reg + 12'd1;
                    end
                end
                DONE, ABORT: begin
                    gnt_reg   <= '0;
                    ptr_reg   <= ptr_next;
                    wdog_reg  <= '0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign o_GNT       = gnt_reg;
    assign o_ACK       = (state_reg == DONE) ? gnt_reg : '0;
    assign o_TIMEOUT   = (state_reg == ABORT);
    assign o_BUSY      = (state_reg != IDLE);
    assign o_TX_ENABLE = (state_reg == START);
    assign o_TX_DATA   = tx_data_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter (4 requesters, 16-cycle watchdog).
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        tout;
    logic        busy;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        tx_done;

    int checks   = 0;
    int failures = 0;

    uart_tx_arbiter #(
        .P_NUM_REQ(4),
        .P_TIMEOUT(16)
    ) dut (
        .i_CLK      (clk),
        .i_RESET_N  (rst_n),
        .i_REQ      (req),
        .i_REQ_DATA (req_data),
        .o_GNT      (gnt),
        .o_ACK      (ack),
        .o_TIMEOUT  (tout),
        .o_BUSY     (busy),
        .o_TX_ENABLE(tx_en),
        .o_TX_DATA  (tx_data),
        .i_TX_DONE  (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs/outputs are handled 1 unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        req      = 4'b1111;
        req_data = 32'hDDCCBBAA;
        tx_done  = 1'b0;
        #1;
        checks++;
        if ({gnt, ack, tout, busy, tx_en, tx_data} !== 19'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {gnt, ack, tout, busy, tx_en, tx_data});
        end
        repeat (2) tick();
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold gnt=%b busy=%b exp gnt=0000 busy=0", gnt, busy);
        end
        req   = 4'b0000;
        rst_n = 1'b1;
        $display("txn reset done");
    endtask

    task automatic test_single();
        req      = 4'b0001;
        req_data = 32'h00000080;
        tick();  // START cycle s
        req = 4'b0000;
        checks++;
        if (tx_en !== 1'b1 || tx_data !== 8'h80 || gnt !== 4'b0001) begin
            failures++;
            $display("FAIL single_start tx_en=%b data=%h gnt=%b exp 1/80/0001", tx_en, tx_data, gnt);
        end
        tick();  // s+1, WAIT
        checks++;
        if (tx_en !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_wait tx_en=%b busy=%b exp 0/1", tx_en, busy);
        end
        repeat (9) tick();  // s+10
        tx_done = 1'b1;
        tick();  // s+11, DONE
        tx_done = 1'b0;
        checks++;
        if (ack !== 4'b0001 || tout !== 1'b0) begin
            failures++;
            $display("FAIL single_ack ack=%b tout=%b exp 0001/0", ack, tout);
        end
        tick();  // IDLE
        checks++;
        if (gnt !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_release gnt=%b ack=%b busy=%b exp 0000/0000/0", gnt, ack, busy);
        end
        $display("txn single req=0 data=%h", tx_data);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        logic [7:0] exp_data;
        int         idx;
        int         ack_cnt;
        // Restart from pointer 0.
        rst_n = 1'b0;
        #2;
        rst_n    = 1'b1;
        req      = 4'b1111;
        req_data = 32'hD3C2B1A0;
        ack_cnt  = 0;
        for (int i = 0; i < 5; i++) begin
            idx      = i % 4;
            exp_gnt  = 4'b0001 << idx;
            exp_data = 8'hA0 + 8'h11 * 8'(idx);
            tick();  // START
            checks++;
            if (gnt !== exp_gnt || tx_en !== 1'b1 || tx_data !== exp_data) begin
                failures++;
                $display("FAIL rr_grant%0d gnt=%b tx_en=%b data=%h exp %b/1/%h", i, gnt, tx_en, tx_data, exp_gnt, exp_data);
            end
            tick();  // WAIT, cycle k
            tx_done = 1'b1;
            tick();  // k+1 DONE
            tx_done = 1'b0;
            if (ack === exp_gnt) ack_cnt++;
            tick();  // k+2 IDLE
            checks++;
            if (busy !== 1'b0 || ack !== 4'b0000) begin
                failures++;
                $display("FAIL rr_idle%0d busy=%b ack=%b exp 0/0000", i, busy, ack);
            end
            $display("txn rr %0d gnt=%b", i, exp_gnt);
        end
        checks++;
        if (ack_cnt !== 5) begin
            failures++;
            $display("FAIL rr_ack_count got=%0d exp=5", ack_cnt);
        end
        req = 4'b0000;
    endtask

    task automatic test_timeout();
        int early;
        // Pointer is 1 here; requester 2 is the only one asking.
        req = 4'b0100;
        tick();  // START
        req = 4'b0000;
        checks++;
        if (gnt !== 4'b0100) begin
            failures++;
            $display("FAIL to_grant gnt=%b exp=0100", gnt);
        end
        tick();  // first WAIT cycle w
        early = 0;
        for (int i = 0; i < 15; i++) begin
            if (tout !== 1'b0 || ack !== 4'b0000) early++;
            tick();
        end
        // now at w+15
        if (tout !== 1'b0) early++;
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL to_early got=%0d exp=0", early);
        end
        tick();  // w+16 ABORT
        checks++;
        if (tout !== 1'b1 || ack !== 4'b0000) begin
            failures++;
            $display("FAIL to_pulse tout=%b ack=%b exp 1/0000", tout, ack);
        end
        tick();  // IDLE
        checks++;
        if (tout !== 1'b0 || gnt !== 4'b0000) begin
            failures++;
            $display("FAIL to_release tout=%b gnt=%b exp 0/0000", tout, gnt);
        end
        // Pointer should be 3: of {0,3}, requester 3 is chosen.
        req = 4'b1001;
        tick();
        req = 4'b0000;
        checks++;
        if (gnt !== 4'b1000) begin
            failures++;
            $display("FAIL to_pointer gnt=%b exp=1000", gnt);
        end
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        $display("txn timeout req=2");
    endtask

    task automatic test_drop_data();
        req      = 4'b0010;
        req_data = 32'h00005A00;
        tick();  // START
        checks++;
        if (gnt !== 4'b0010 || tx_data !== 8'h5A) begin
            failures++;
            $display("FAIL drop_grant gnt=%b data=%h exp 0010/5a", gnt, tx_data);
        end
        req      = 4'b0000;
        req_data = 32'h0000FF00;
        repeat (4) tick();  // WAIT
        checks++;
        if (tx_data !== 8'h5A || gnt !== 4'b0010) begin
            failures++;
            $display("FAIL drop_hold data=%h gnt=%b exp 5a/0010", tx_data, gnt);
        end
        tx_done = 1'b1;
        tick();  // DONE
        tx_done = 1'b0;
        checks++;
        if (ack !== 4'b0010 || tx_data !== 8'h5A) begin
            failures++;
            $display("FAIL drop_ack ack=%b data=%h exp 0010/5a", ack, tx_data);
        end
        tick();
        $display("txn drop req=1 data=%h", tx_data);
    endtask

    task automatic test_reset_mid_wait();
        int stray;
        req      = 4'b0001;
        req_data = 32'h00000042;
        tick();  // START
        req = 4'b0000;
        repeat (3) tick();  // WAIT
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, ack, tout, busy, tx_en, tx_data} !== 19'd0) begin
            failures++;
            $display("FAIL rst_mid_outputs got=%h exp=0", {gnt, ack, tout, busy, tx_en, tx_data});
        end
        req      = 4'b1000;
        req_data = 32'h77000000;
        tick();
        rst_n = 1'b1;
        tick();  // first edge with reset high -> START
        req = 4'b0000;
        checks++;
        if (gnt !== 4'b1000 || tx_en !== 1'b1 || tx_data !== 8'h77) begin
            failures++;
            $display("FAIL rst_mid_regrant gnt=%b tx_en=%b data=%h exp 1000/1/77", gnt, tx_en, tx_data);
        end
        stray = 0;
        tick();
        tx_done = 1'b1;
        tick();  // DONE
        tx_done = 1'b0;
        if (ack !== 4'b1000) stray++;
        tick();
        if (ack !== 4'b0000 || tout !== 1'b0) stray++;
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL rst_mid_complete got=%0d exp=0", stray);
        end
        $display("txn reset_mid_wait regrant=3");
    endtask

    task automatic test_spurious_coincide();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || ack !== 4'b0000 || tout !== 1'b0) begin
            failures++;
            $display("FAIL spur_idle busy=%b ack=%b tout=%b exp 0/0000/0", busy, ack, tout);
        end
        req = 4'b0001;
        tick();  // START
        req = 4'b0000;
        tick();  // WAIT cycle w, watchdog 0
        repeat (15) tick();  // w+15, watchdog at expiry value
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        checks++;
        if (ack !== 4'b0001 || tout !== 1'b0) begin
            failures++;
            $display("FAIL coincide_ack ack=%b tout=%b exp 0001/0", ack, tout);
        end
        tick();
        checks++;
        if (tout !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL coincide_after tout=%b busy=%b exp 0/0", tout, busy);
        end
        $display("txn coincide req=0");
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_drop_data();
        test_reset_mid_wait();
        test_spurious_coincide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_time_limit expired");
        $fatal(1, "time limit");
    end

endmodule
